// File: rtl/binary_mul_arb_pkg.sv
// binary_mul_arb_pkg: shared FSM state type, default sizes and pointer helper
package binary_mul_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam int N_REQ_DEF   = 4;
  localparam int WIDTH_DEF   = 7;
  localparam int MUL_LAT_DEF = 1;
  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/binary_mul_arb_if.sv
// binary_mul_arb_if: request, multiplier and response signals of the shared multiplier arbiter
// slave modport: arbiter side; master modport: clients + multiplier side.
// With BINARY_MUL_ARB_STATS_EN defined, op_count and busy are added.
interface binary_mul_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 7,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   mul_en;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [2*WIDTH-1:0]     mul_p;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [2*WIDTH-1:0]     rsp_p;
`ifdef BINARY_MUL_ARB_STATS_EN
  logic [15:0]            op_count;
  logic                   busy;
`endif
  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
`ifdef BINARY_MUL_ARB_STATS_EN
    , output op_count, busy
`endif
  );
  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
`ifdef BINARY_MUL_ARB_STATS_EN
    , input op_count, busy
`endif
  );
endinterface

// File: rtl/binary_mul_rr_arb.sv
// binary_mul_rr_arb: combinational round-robin grant starting at ptr_i
// valid_i: requests; ptr_i: highest-priority index; grant_o: one-hot grant;
// idx_o: binary grant index; any_o: some request is valid.
module binary_mul_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Walk from farthest to nearest so the first valid after ptr_i wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_i[(int'(ptr_i) + k) % N_REQ]) begin
        grant_o = N_REQ'(1) << ((int'(ptr_i) + k) % N_REQ);
        idx_o   = ID_W'((int'(ptr_i) + k) % N_REQ);
        any_o   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/binary_mul_arb.sv
// binary_mul_arb: round-robin sequencer sharing one registered multiplier among N_REQ clients
// clk, rst_n (async, active-low); bus (slave): per-client req_valid/req_ready/req_a/req_b,
// multiplier mul_en/mul_a/mul_b/mul_p, response rsp_valid/rsp_ready/rsp_id/rsp_p.
// BINARY_MUL_ARB_STATS_EN adds op_count (response handshakes, wraps) and busy.
module binary_mul_arb
  import binary_mul_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst_n,
  binary_mul_arb_if.slave   bus
);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, g_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] rsp_p_q, rsp_p_d;
  logic               rsp_valid_q, rsp_valid_d, g_any;
  logic [N_REQ-1:0]   g_oh;
  binary_mul_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .valid_i(bus.req_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(g_oh),
    .idx_o  (g_idx),
    .any_o  (g_any)
  );
  assign bus.req_ready = (state_q == IDLE) ? g_oh : '0;
  assign bus.mul_en    = state_q == ISSUE;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    case (state_q)
      IDLE: if (g_any) begin
        mul_a_d  = bus.req_a[int'(g_idx)*WIDTH +: WIDTH];
        mul_b_d  = bus.req_b[int'(g_idx)*WIDTH +: WIDTH];
        id_d     = g_idx;
        rr_ptr_d = ID_W'(rr_inc(int'(g_idx), N_REQ));
        state_d  = ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MUL_LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        rsp_p_d     = bus.mul_p;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
    end
  end
`ifdef BINARY_MUL_ARB_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  assign op_count_d   = op_count_q + 16'((rsp_valid_q && bus.rsp_ready) ? 1 : 0);
  assign bus.op_count = op_count_q;
  assign bus.busy     = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end
`endif
endmodule

// File: tb/tb_binary_mul_arb.sv
// tb_binary_mul_arb: randomized scoreboard bench for binary_mul_arb with a behavioural multiplier
module tb_binary_mul_arb;
  localparam int N = 4;
  localparam int W = 7;
`ifdef BINARY_MUL_ARB_STATS_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  typedef struct {int id; logic [2*W-1:0] p; int acc;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  binary_mul_arb_if #(.N_REQ(N), .WIDTH(W)) bus();
  binary_mul_arb #(.N_REQ(N), .WIDTH(W), .MUL_LAT(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Registered multiplier: product visible L edges after the edge that samples en.
  logic [2*W-1:0] stg [L];
  always @(posedge clk) begin
    if (bus.mul_en) stg[0] <= (2*W)'(bus.mul_a) * (2*W)'(bus.mul_b);
    for (int i = 1; i < L; i++) stg[i] <= stg[i-1];
  end
  assign bus.mul_p = stg[L-1];

  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  logic [2*W-1:0] opq [N][$];
  logic [N-1:0] hs;
  bit rnd_mode = 0, ready_knob = 1, chk_int = 0, busy = 0;
  int ptr = 0, last_acc = -1, n_ops = 0;
  logic prev_v = 0, prev_r = 0;
  logic [1:0] prev_id;
  logic [2*W-1:0] prev_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reference arbitration model and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      ptr = 0; busy = 0; n_ops = 0; hs = '0; prev_v = 0; prev_r = 0; last_acc = -1;
      q.delete();
    end else begin
      int g;
      logic [W-1:0] a, b;
      g = -1;
      if (!busy)
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req_valid[(ptr + k) % N]) g = (ptr + k) % N;
      chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
`ifdef BINARY_MUL_ARB_STATS_EN
      chk("op_count", 32'(bus.op_count), 32'(n_ops));
      chk("busy", 32'(bus.busy), 32'(busy));
`endif
      hs = bus.req_valid & bus.req_ready;
      if (g >= 0) begin
        a = bus.req_a[g*W +: W];
        b = bus.req_b[g*W +: W];
        q.push_back('{g, (2*W)'(a) * (2*W)'(b), cyc + 1});
        if (chk_int && last_acc >= 0) chk("issue_interval", 32'(cyc + 1 - last_acc), 32'(L + 3));
        last_acc = cyc + 1;
        busy = 1;
        ptr = (g + 1) % N;
      end
      if (prev_v && !prev_r) begin
        chk("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_hold_id", 32'(bus.rsp_id), 32'(prev_id));
        chk("rsp_hold_p", 32'(bus.rsp_p), 32'(prev_p));
      end
      if (bus.rsp_valid && !prev_v && q.size() > 0) chk("latency", 32'(cyc - q[0].acc), 32'(L + 1));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_p", 32'(bus.rsp_p), 32'(e.p));
        end
        busy = 0;
        n_ops = (n_ops + 1) % 65536;
      end
      prev_v = bus.rsp_valid; prev_r = bus.rsp_ready; prev_id = bus.rsp_id; prev_p = bus.rsp_p;
    end
  end

  // Driver: raises requests from per-client operand queues, consumes them on handshake.
  initial begin
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_knob;
      for (int i = 0; i < N; i++) begin
        bit dropped;
        dropped = 0;
        if (hs[i]) begin
          void'(opq[i].pop_front());
          bus.req_valid[i] = 1'b0;
        end else if (bus.req_valid[i] && rnd_mode && $urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
          dropped = 1;
        end
        if (!dropped && !bus.req_valid[i] && opq[i].size() > 0 && !(rnd_mode && $urandom_range(0, 2) == 0)) begin
          bus.req_a[i*W +: W] = opq[i][0][2*W-1:W];
          bus.req_b[i*W +: W] = opq[i][0][W-1:0];
          bus.req_valid[i] = 1'b1;
        end
      end
    end
  end

  task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    opq[i].push_back({a, b});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((opq[0].size() + opq[1].size() + opq[2].size() + opq[3].size() > 0 || busy || bus.req_valid != '0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'(n), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_mul_en", 32'(bus.mul_en), 0);
    chk("rst_mul_a", 32'(bus.mul_a), 0);
    chk("rst_mul_b", 32'(bus.mul_b), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_p", 32'(bus.rsp_p), 0);
`ifdef BINARY_MUL_ARB_STATS_EN
    chk("rst_op_count", 32'(bus.op_count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // single request, max operands
    push(2, 7'd127, 7'd127);
    drain();
    // every client continuously valid with immediate response acceptance
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, W'($urandom), W'($urandom));
    last_acc = -1;
    chk_int = 1;
    drain();
    chk_int = 0;
    // response backpressure
    ready_knob = 0;
    push(1, 7'd99, 7'd77);
    for (int n = 0; n < 50 && !bus.rsp_valid; n++) @(negedge clk);
    chk("bp_rsp_seen", 32'(bus.rsp_valid), 1);
    repeat (10) @(negedge clk);
    ready_knob = 1;
    drain();
    // zero / max / power-of-two operands
    push(0, 7'd0, 7'd63);
    push(1, 7'd127, 7'd1);
    push(3, 7'd64, 7'd64);
    drain();
    // asynchronous reset while the product is being waited for
    push(2, 7'd55, 7'd44);
    for (int n = 0; n < 50 && !bus.mul_en; n++) @(negedge clk);
    chk("rstmid_issue_seen", 32'(bus.mul_en), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    push(3, 7'd12, 7'd11);
    push(1, 7'd5, 7'd9);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain();
    // randomized traffic with random valid drops and backpressure
    rnd_mode = 1;
    for (int k = 0; k < 40; k++) push($urandom_range(0, N - 1), W'($urandom), W'($urandom));
    drain();
    rnd_mode = 0;
    drain();
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/binary_mul_arb.md
Name: binary_mul_arb

Overview:
Round-robin arbiter and sequencer that shares one registered unsigned WIDTH x WIDTH multiplier among N_REQ requesters.
- The multiplier has an en input and a registered product P.
- The block accepts one operand pair at a time over valid/ready and drives the multiplier's A/B/en.
- It waits out the multiplier latency, then returns the product tagged with the requester id over a valid/ready response channel.
- It sits between client blocks and the shared multiplier instance.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 7, operand width; product is 2*WIDTH
MUL_LAT, 1, multiplier latency in cycles from en-sampled edge to P valid (>=1)
ID_W, $clog2(N_REQ), requester id width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, at most one bit high
req_a  in  N_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  packed operand B, same packing
mul_en  out  1  multiplier enable
mul_a  out  WIDTH  multiplier operand A
mul_b  out  WIDTH  multiplier operand B
mul_p  in  2*WIDTH  multiplier product
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  id of requester that owns rsp_p
rsp_p  out  2*WIDTH  product

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, mul_en=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_p=0, req_ready=0, op counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The grant is combinational.
  - Grant goes to the first i with req_valid[i] in search order rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
  - req_ready[grant]=1 only in IDLE.
  - On handshake (req_valid & req_ready): latch operands into mul_a/mul_b, latch id, set rr_ptr=(grant+1) mod N_REQ, go to ISSUE.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - mul_en=1 for exactly this one cycle; mul_a/mul_b stable.
  - Next state WAIT with cnt=MUL_LAT-1.
- WAIT:
  - mul_en=0; mul_a/mul_b held.
  - If cnt==0: rsp_p<=mul_p, rsp_id<=latched id, rsp_valid<=1, go to RESP.
  - Else decrement cnt.
- RESP:
  - rsp_valid, rsp_id and rsp_p are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
  - req_ready=0 throughout RESP.
- Latency: rsp_valid rises on the (MUL_LAT+1)th rising edge after the accept edge.
  - Minimum issue interval with rsp_ready tied high is MUL_LAT+3 cycles.
- Exactly one operation is in flight; requests arriving in ISSUE/WAIT/RESP wait with req_ready=0.
- Fairness: a continuously valid requester is granted within N_REQ operations.
- Requester dropping req_valid before grant: no effect, no state change.
- Arithmetic: unsigned; the product is taken from mul_p unmodified (no truncation, full 2*WIDTH). Zero operands follow the normal flow.
- Reset mid-operation: async reset aborts the in-flight op immediately.
  - All outputs return to reset values; any partially waited product is discarded.
  - rr_ptr returns to 0.

Optional Feature:
BINARY_MUL_ARB_STATS_EN
- Defined: adds output port op_count [15:0].
  - Increments on each response handshake (rsp_valid & rsp_ready).
  - Wraps 0xFFFF->0; reset to 0.
  - Adds output busy (1 when state != IDLE).
- Undefined: ports and counter absent; no other behaviour change.

Decomposition:
- Package binary_mul_arb_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP, 2-bit encoding).
  - Default-width localparams.
  - Function for the mod-N_REQ pointer increment.
- One sub-module, binary_mul_rr_arb:
  - Combinational round-robin grant from req_valid and rr_ptr.
  - Outputs a one-hot grant and its binary index.
- Top instantiates it; it does not instantiate the multiplier (connected externally).

Test Plan:
- Reset then single request: req 2 valid, A=127, B=127, MUL_LAT=1 -> req_ready[2] in IDLE; rsp_valid 2 edges after accept with rsp_id=2, rsp_p=16129.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; products correct; one response every 4 cycles.
- Backpressure: rsp_ready=0 for 10 cycles during RESP -> rsp_valid/rsp_id/rsp_p stable; req_ready all 0; single rsp handshake when released.
- Zero and max mix: A=0,B=63 -> 0; A=127,B=1 -> 127; A=64,B=64 -> 4096, ids preserved.
- Async reset asserted mid-WAIT -> all outputs 0 immediately, no response emitted; next request after release is served with rr_ptr=0 priority.
- With BINARY_MUL_ARB_STATS_EN and MUL_LAT=3: 5 ops -> op_count=5; busy high from accept to response handshake; latency 4 edges.
